// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: control inputs, instruction-memory handshake and IF/ID-facing outputs.
// Optional perf counters (fetch_cnt, stall_cnt) appear only when IF_PERF_CNT_EN is defined.
interface if_fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic        valid_out;
  logic        ifid_write;
  logic        flush_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  modport master (
    input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc_out, ir_out, valid_out, ifid_write, flush_out
`ifdef IF_PERF_CNT_EN
    , output fetch_cnt, stall_cnt
`endif
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc_out, ir_out, valid_out, ifid_write, flush_out
`ifdef IF_PERF_CNT_EN
    , input fetch_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, stall hold, redirect with kill of in-flight data.
// Define IF_PERF_CNT_EN to add the fetch_cnt / stall_cnt performance counters.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  if_fetch_if.master fb
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_KILL} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_kill_addr, w_kill_addr_nxt;
  logic [31:0] r_pc_out, w_pc_out_nxt;
  logic [31:0] r_ir, w_ir_nxt;
  logic        r_valid, w_valid_nxt;
  logic        w_accept;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = fb.redirect_pc & ~32'd3;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_kill_addr_nxt = r_kill_addr;
    w_pc_out_nxt    = r_pc_out;
    w_ir_nxt        = r_ir;
    w_valid_nxt     = r_valid;
    w_accept        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (fb.redirect) w_pc_nxt = w_redir_pc;
      end
      S_REQ: begin
        if (fb.redirect) begin
          w_pc_nxt        = w_redir_pc;
          w_valid_nxt     = 1'b0;
          w_kill_addr_nxt = r_pc;
          w_state_nxt     = fb.imem_ack ? S_REQ : S_KILL;
        end else if (fb.imem_ack) begin
          w_accept     = 1'b1;
          w_pc_out_nxt = r_pc;
          w_ir_nxt     = fb.imem_rdata;
          w_valid_nxt  = 1'b1;
          if (fb.stall) w_state_nxt = S_HOLD;
          else          w_pc_nxt    = r_pc + 32'd4;
        end else if (r_valid && !fb.stall) begin
          w_valid_nxt = 1'b0;
        end
      end
      S_HOLD: begin
        if (fb.redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
        end else if (!fb.stall) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
        end
      end
      S_KILL: begin
        // Old request stays on the bus; only the restart target moves.
        if (fb.redirect) w_pc_nxt = w_redir_pc;
        if (fb.imem_ack) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_kill_addr <= 32'd0;
      r_pc_out    <= 32'd0;
      r_ir        <= 32'd0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_kill_addr <= w_kill_addr_nxt;
      r_pc_out    <= w_pc_out_nxt;
      r_ir        <= w_ir_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  assign fb.imem_req   = (r_state == S_REQ) || (r_state == S_KILL);
  assign fb.imem_addr  = (r_state == S_KILL) ? r_kill_addr :
                         (r_state == S_REQ)  ? r_pc : 32'd0;
  assign fb.pc_out     = r_pc_out;
  assign fb.ir_out     = r_ir;
  assign fb.valid_out  = r_valid;
  assign fb.ifid_write = r_valid & ~fb.stall & ~fb.redirect;
  assign fb.flush_out  = fb.redirect;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_accept)           r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_state == S_HOLD)  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fb.fetch_cnt = r_fetch_cnt;
  assign fb.stall_cnt = r_stall_cnt;
`endif

endmodule
